// File: rtl/xor_scr_pkg.sv
// Shared types and keystream helper for the xor8 descrambler.
// Galois LFSR step used by the receive-side keystream.
package xor_scr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] POLY_DEF = 8'hB8;
  localparam logic [7:0] SEED_DEF = 8'hFF;

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] x,
    input logic [7:0] poly
  );
    lfsr_step = (x >> 1) ^ (x[0] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/lfsr_galois8.sv
// Combinational next state of the 8-bit Galois keystream.
// Right-shift form, feedback mask POLY.
module lfsr_galois8
  import xor_scr_pkg::*;
#(
  parameter logic [7:0] POLY = POLY_DEF
) (
  input  logic [7:0] cur,
  output logic [7:0] nxt
);

  assign nxt = lfsr_step(cur, POLY);

endmodule

// File: rtl/xor8_descrambler.sv
// Receive-side descrambler: XORs accepted bytes with an LFSR
// keystream, one output register stage, valid/ready both sides.
module xor8_descrambler
  import xor_scr_pkg::*;
#(
  parameter logic [7:0] POLY  = POLY_DEF,
  parameter logic [7:0] SEED  = SEED_DEF,
  parameter int         CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       seed,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] byte_cnt
);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_nxt;
  logic       accept;

  lfsr_galois8 #(
    .POLY(POLY)
  ) u_lfsr (
    .cur(lfsr_q),
    .nxt(lfsr_nxt)
  );

  assign busy     = (state_q == RUN);
  assign in_ready = busy && !start && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      start:              state_d = RUN;
      accept && in_last:  state_d = IDLE;
      default:            state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Keystream only moves on accepted bytes; a zero seed would lock up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q   <= SEED;
      byte_cnt <= '0;
    end else if (start) begin
      lfsr_q   <= (seed == 8'h00) ? SEED : seed;
      byte_cnt <= '0;
    end else if (accept) begin
      lfsr_q <= lfsr_nxt;
      if (byte_cnt != '1) begin
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_data  <= in_data ^ lfsr_q;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
